// File: rtl/postprocess_pool_window.sv
`default_nettype none
// ============================================================================
//  Module   : postprocess_pool_window
//  Purpose  : Gathers non-overlapping 2x2 windows from a raster pixel stream
//             and presents them, with their pooled-output index, to the pool.
//  Revision : 1.0  initial release
// ============================================================================
module postprocess_pool_window #(
    parameter int IMG_W = 24,
    parameter int IMG_H = 24
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       in_valid,
    input  logic [7:0] data_in,
    output logic       win_valid,
    output logic [8:0] iter_out,
    output logic [7:0] data_out0,
    output logic [7:0] data_out1,
    output logic [7:0] data_out2,
    output logic [7:0] data_out3,
    output logic       frame_done
);

    localparam int c_col_w = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int c_row_w = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    logic [c_col_w-1:0] r_col_q,  w_col_d;
    logic [c_row_w-1:0] r_row_q,  w_row_d;
    logic [8:0]         r_iter_q, w_iter_d;

    logic               r_win_valid_q,  w_win_valid_d;
    logic               r_frame_done_q, w_frame_done_d;
    logic [8:0]         r_iter_out_q,   w_iter_out_d;
    logic [7:0]         r_dout0_q, w_dout0_d;
    logic [7:0]         r_dout1_q, w_dout1_d;
    logic [7:0]         r_dout2_q, w_dout2_d;
    logic [7:0]         r_dout3_q, w_dout3_d;

    logic [7:0]         r_line_buf_q [IMG_W];
    logic [7:0]         r_held_pix_q;

    logic               w_accept;
    logic               w_last_col;
    logic               w_last_row;
    logic               w_complete;
    logic               w_lb_we;
    logic               w_held_we;
    logic [c_col_w-1:0] w_col_even;

    always_comb begin
        w_accept   = in_valid & ~clear;
        w_last_col = (r_col_q == c_col_w'(IMG_W - 1));
        w_last_row = (r_row_q == c_row_w'(IMG_H - 1));
        w_complete = w_accept & r_row_q[0] & r_col_q[0];
        w_lb_we    = w_accept & ~r_row_q[0];
        w_held_we  = w_accept &  r_row_q[0] & ~r_col_q[0];
        // Top-left pixel of the window sits at the even column just left of us
        w_col_even = r_col_q & ~c_col_w'(1);
    end

    always_comb begin
        w_col_d        = r_col_q;
        w_row_d        = r_row_q;
        w_iter_d       = r_iter_q;
        w_win_valid_d  = 1'b0;
        w_frame_done_d = 1'b0;
        w_iter_out_d   = r_iter_out_q;
        w_dout0_d      = r_dout0_q;
        w_dout1_d      = r_dout1_q;
        w_dout2_d      = r_dout2_q;
        w_dout3_d      = r_dout3_q;

        if (clear) begin
            w_col_d  = '0;
            w_row_d  = '0;
            w_iter_d = '0;
        end else if (w_accept) begin
            if (w_last_col) begin
                w_col_d = '0;
                w_row_d = w_last_row ? '0 : r_row_q + c_row_w'(1);
            end else begin
                w_col_d = r_col_q + c_col_w'(1);
            end

            if (w_complete) begin
                w_win_valid_d  = 1'b1;
                w_frame_done_d = w_last_col & w_last_row;
                w_iter_out_d   = r_iter_q;
                w_dout0_d      = r_line_buf_q[w_col_even];
                w_dout1_d      = r_line_buf_q[r_col_q];
                w_dout2_d      = r_held_pix_q;
                w_dout3_d      = data_in;
                // Explicit wrap keeps the index frame-aligned for any legal size
                w_iter_d       = (w_last_col & w_last_row) ? 9'd0 : r_iter_q + 9'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_col_q        <= '0;
            r_row_q        <= '0;
            r_iter_q       <= '0;
            r_win_valid_q  <= 1'b0;
            r_frame_done_q <= 1'b0;
            r_iter_out_q   <= '0;
            r_dout0_q      <= '0;
            r_dout1_q      <= '0;
            r_dout2_q      <= '0;
            r_dout3_q      <= '0;
        end else begin
            r_col_q        <= w_col_d;
            r_row_q        <= w_row_d;
            r_iter_q       <= w_iter_d;
            r_win_valid_q  <= w_win_valid_d;
            r_frame_done_q <= w_frame_done_d;
            r_iter_out_q   <= w_iter_out_d;
            r_dout0_q      <= w_dout0_d;
            r_dout1_q      <= w_dout1_d;
            r_dout2_q      <= w_dout2_d;
            r_dout3_q      <= w_dout3_d;
        end
    end

    // Storage is always written before it is read, so it carries no reset
    always_ff @(posedge clk) begin
        if (w_lb_we) begin
            r_line_buf_q[r_col_q] <= data_in;
        end
        if (w_held_we) begin
            r_held_pix_q <= data_in;
        end
    end

    assign win_valid  = r_win_valid_q;
    assign frame_done = r_frame_done_q;
    assign iter_out   = r_iter_out_q;
    assign data_out0  = r_dout0_q;
    assign data_out1  = r_dout1_q;
    assign data_out2  = r_dout2_q;
    assign data_out3  = r_dout3_q;

endmodule
`default_nettype wire

// File: tb/tb_postprocess_pool_window.sv
`default_nettype none
// ============================================================================
//  Module   : tb_postprocess_pool_window
//  Purpose  : Self-checking bench for the 2x2 window gatherer (4x4 frames).
//  Revision : 1.0  initial release
// ============================================================================
module tb_postprocess_pool_window;

    localparam int W = 4;
    localparam int H = 4;

    logic       clk;
    logic       rst;
    logic       clear;
    logic       in_valid;
    logic [7:0] data_in;
    logic       win_valid;
    logic [8:0] iter_out;
    logic [7:0] data_out0, data_out1, data_out2, data_out3;
    logic       frame_done;

    postprocess_pool_window #(.IMG_W(W), .IMG_H(H)) dut (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear),
        .in_valid   (in_valid),
        .data_in    (data_in),
        .win_valid  (win_valid),
        .iter_out   (iter_out),
        .data_out0  (data_out0),
        .data_out1  (data_out1),
        .data_out2  (data_out2),
        .data_out3  (data_out3),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 0;

    task automatic chk(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d at %0t", name, act, req, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    typedef struct packed {
        logic [7:0] d0, d1, d2, d3;
        logic [8:0] it;
        logic       fd;
    } win_t;

    win_t       exp_log[$];
    logic [7:0] frame [W*H];
    int         m_col = 0, m_row = 0;
    logic       exp_wv = 0, exp_fd = 0;
    logic [8:0] exp_iter = 0;
    logic [7:0] exp_d0 = 0, exp_d1 = 0, exp_d2 = 0, exp_d3 = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_col = 0; m_row = 0;
            exp_wv = 0; exp_fd = 0; exp_iter = 0;
            exp_d0 = 0; exp_d1 = 0; exp_d2 = 0; exp_d3 = 0;
        end else begin
            exp_wv = 0;
            exp_fd = 0;
            if (clear) begin
                m_col = 0;
                m_row = 0;
            end else if (in_valid) begin
                int pos;
                pos = m_row * W + m_col;
                frame[pos] = data_in;
                if ((m_row % 2 == 1) && (m_col % 2 == 1)) begin
                    win_t w;
                    exp_d0   = frame[pos - W - 1];
                    exp_d1   = frame[pos - W];
                    exp_d2   = frame[pos - 1];
                    exp_d3   = frame[pos];
                    exp_iter = 9'((m_row / 2) * (W / 2) + m_col / 2);
                    exp_wv   = 1;
                    exp_fd   = (pos == W * H - 1);
                    w.d0 = exp_d0; w.d1 = exp_d1; w.d2 = exp_d2; w.d3 = exp_d3;
                    w.it = exp_iter; w.fd = exp_fd;
                    exp_log.push_back(w);
                end
                m_col++;
                if (m_col == W) begin
                    m_col = 0;
                    m_row++;
                    if (m_row == H) m_row = 0;
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            chk("win_valid",  int'(win_valid),  int'(exp_wv));
            chk("frame_done", int'(frame_done), int'(exp_fd));
            chk("iter_out",   int'(iter_out),   int'(exp_iter));
            chk("data_out0",  int'($signed(data_out0)), int'($signed(exp_d0)));
            chk("data_out1",  int'($signed(data_out1)), int'($signed(exp_d1)));
            chk("data_out2",  int'($signed(data_out2)), int'($signed(exp_d2)));
            chk("data_out3",  int'($signed(data_out3)), int'($signed(exp_d3)));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic push(input logic [7:0] d, input int gap);
        @(posedge clk); #1;
        in_valid = 1; data_in = d; clear = 0;
        repeat (gap) begin
            @(posedge clk); #1;
            in_valid = 0; data_in = 8'($urandom);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            in_valid = 0; clear = 0;
        end
    endtask

    task automatic send_frame(input int base, input int gap);
        for (int i = 0; i < W * H; i++) push(8'(base + i), gap);
    endtask

    task automatic check_win(input string name, input int idx,
                             input int a, input int b, input int c, input int d,
                             input int it, input int fd);
        if (idx >= exp_log.size()) begin
            chk({name, "_present"}, exp_log.size(), idx + 1);
        end else begin
            chk({name, "_d0"}, int'($signed(exp_log[idx].d0)), a);
            chk({name, "_d1"}, int'($signed(exp_log[idx].d1)), b);
            chk({name, "_d2"}, int'($signed(exp_log[idx].d2)), c);
            chk({name, "_d3"}, int'($signed(exp_log[idx].d3)), d);
            chk({name, "_it"}, int'(exp_log[idx].it), it);
            chk({name, "_fd"}, int'(exp_log[idx].fd), fd);
        end
    endtask

    task automatic check_basic_frame(input string name, input int base);
        chk({name, "_count"}, exp_log.size(), 4);
        check_win({name, "_w0"}, 0, base + 0,  base + 1,  base + 4,  base + 5,  0, 0);
        check_win({name, "_w1"}, 1, base + 2,  base + 3,  base + 6,  base + 7,  1, 0);
        check_win({name, "_w2"}, 2, base + 8,  base + 9,  base + 12, base + 13, 2, 0);
        check_win({name, "_w3"}, 3, base + 10, base + 11, base + 14, base + 15, 3, 1);
    endtask

    task automatic check_zero(input string name);
        chk({name, "_wv"}, int'(win_valid), 0);
        chk({name, "_fd"}, int'(frame_done), 0);
        chk({name, "_it"}, int'(iter_out), 0);
        chk({name, "_d0"}, int'(data_out0), 0);
        chk({name, "_d1"}, int'(data_out1), 0);
        chk({name, "_d2"}, int'(data_out2), 0);
        chk({name, "_d3"}, int'(data_out3), 0);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        clk = 0; rst = 1; clear = 0; in_valid = 0; data_in = 0;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        rst = 0;
        chk_en = 1;

        // 1: continuous 0..15
        exp_log.delete();
        send_frame(0, 0);
        idle(2);
        check_basic_frame("s1", 0);

        // 2: 3-cycle gaps after every pixel
        exp_log.delete();
        send_frame(0, 3);
        idle(2);
        check_basic_frame("s2", 0);

        // 3: signed pattern
        exp_log.delete();
        for (int i = 0; i < W * H; i++) begin
            case (i % 4)
                0: push(8'h80, 0);
                1: push(8'h7F, 0);
                2: push(8'hFF, 0);
                default: push(8'h00, 0);
            endcase
        end
        idle(2);
        check_win("s3_first", 0, -128, 127, -128, 127, 0, 0);
        check_win("s3_second", 1, -1, 0, -1, 0, 1, 0);

        // 4: back-to-back frames
        exp_log.delete();
        send_frame(0, 0);
        send_frame(16, 0);
        idle(2);
        chk("s4_count", exp_log.size(), 8);
        check_win("s4_f2w0", 4, 16, 17, 20, 21, 0, 0);
        check_win("s4_f2w3", 7, 26, 27, 30, 31, 3, 1);

        // 5: partial frame, clear together with a pixel, then full frame
        for (int i = 0; i < 7; i++) push(8'(i), 0);
        @(posedge clk); #1;
        clear = 1; in_valid = 1; data_in = 8'd99;
        exp_log.delete();
        @(posedge clk); #1;
        clear = 0; in_valid = 0;
        send_frame(0, 0);
        idle(2);
        check_basic_frame("s5", 0);

        // 6: reset during pixel 9
        for (int i = 0; i < 9; i++) push(8'(i), 0);
        @(posedge clk); #1;
        in_valid = 1; data_in = 8'd9;
        #2 rst = 1;
        #1 check_zero("s6_rst");
        @(posedge clk); #1;
        rst = 0; in_valid = 0;
        exp_log.delete();
        send_frame(0, 0);
        idle(2);
        check_basic_frame("s6", 0);

        // Randomized traffic with gaps and occasional clears
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                @(posedge clk); #1;
                clear = 1; in_valid = 1'($urandom); data_in = 8'($urandom);
                @(posedge clk); #1;
                clear = 0; in_valid = 0;
            end else begin
                push(8'($urandom), $urandom_range(0, 2));
            end
        end
        idle(4);

        chk_en = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
